// File: rtl/sm_run_ctrl.sv
// Run/step controller for the stack machine's 5-phase instruction sequencer.
// Issues instructions in free-run or single-step, stops on request/HALT/breakpoint.
module sm_run_ctrl #(
    parameter int CNT_W = 16,
    parameter int PC_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_step,
    input  logic             i_stop,
    input  logic             i_clr_cnt,
    input  logic             i_s00_idle,
    input  logic             i_s03_exec,
    input  logic             i_s04_wtbk,
    input  logic             i_halt_req,
    input  logic [PC_W-1:0]  i_pc,
    input  logic             i_brk_en,
    input  logic [PC_W-1:0]  i_brk_addr,
    output logic             o_run,
    output logic             o_busy,
    output logic [1:0]       o_stop_cause,
    output logic [CNT_W-1:0] o_inst_cnt,
    output logic             o_cnt_ovf
);

    // state    | meaning
    // ST_IDLE  | no instruction issue, waiting for start/step
    // ST_RUN   | free-run, stop at an instruction boundary on request
    // ST_STEP  | issue exactly one instruction, then back to idle
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;

    logic [1:0]       r_state;
    logic             r_stop_pend;
    logic             r_halt_pend;
    logic             r_issued;
    logic [1:0]       r_stop_cause;
    logic [CNT_W-1:0] r_inst_cnt;
    logic             r_cnt_ovf;

    logic       w_brk_match;
    logic       w_run;
    logic       w_busy;
    logic       w_run_end;
    logic       w_step_end;
    logic [1:0] w_cause;

    assign w_brk_match = i_s04_wtbk & i_brk_en & (i_pc == i_brk_addr);
    assign w_busy      = (r_state != ST_IDLE);
    assign w_run       = i_s00_idle & ~i_stop &
                         (((r_state == ST_RUN) & ~r_stop_pend) |
                          ((r_state == ST_STEP) & ~r_issued));
    assign w_run_end   = (r_state == ST_RUN) & i_s04_wtbk &
                         (r_stop_pend | i_stop | r_halt_pend | w_brk_match);
    assign w_step_end  = (r_state == ST_STEP) & i_s04_wtbk;

    always_comb begin
        w_cause = 2'd0;
        if (r_halt_pend)                w_cause = 2'd2;
        else if (w_brk_match)           w_cause = 2'd3;
        else if (r_state == ST_STEP)    w_cause = 2'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_stop_pend  <= 1'b0;
            r_halt_pend  <= 1'b0;
            r_issued     <= 1'b0;
            r_stop_cause <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start || i_step) begin
                        r_state     <= i_start ? ST_RUN : ST_STEP;
                        r_stop_pend <= 1'b0;
                        r_halt_pend <= 1'b0;
                        r_issued    <= 1'b0;
                    end
                end
                ST_RUN, ST_STEP: begin
                    if (i_stop)                   r_stop_pend <= 1'b1;
                    if (i_s03_exec && i_halt_req) r_halt_pend <= 1'b1;
                    if (w_run && (r_state == ST_STEP)) r_issued <= 1'b1;
                    // the in-flight instruction always completes; leave only at writeback
                    if (w_run_end || w_step_end) begin
                        r_state      <= ST_IDLE;
                        r_stop_cause <= w_cause;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr_cnt) begin
            r_inst_cnt <= '0;
            r_cnt_ovf  <= 1'b0;
        end else if (i_s04_wtbk && w_busy) begin
            r_inst_cnt <= r_inst_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (&r_inst_cnt) r_cnt_ovf <= 1'b1;
        end
    end

    assign o_run        = w_run;
    assign o_busy       = w_busy;
    assign o_stop_cause = r_stop_cause;
    assign o_inst_cnt   = r_inst_cnt;
    assign o_cnt_ovf    = r_cnt_ovf;

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Bench for sm_run_ctrl: a 5-phase sequencer model plus a per-session reference
// model that predicts where each run/step session ends and why.
module tb_sm_run_ctrl;
    localparam int CNT_W = 4;
    localparam int PC_W  = 16;
    localparam int CNT_M = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst, start, step, stop, clr_cnt;
    logic             s00_idle, s03_exec, s04_wtbk, halt_req;
    logic [PC_W-1:0]  pc;
    logic             brk_en;
    logic [PC_W-1:0]  brk_addr;
    logic             run, busy, cnt_ovf;
    logic [1:0]       stop_cause;
    logic [CNT_W-1:0] inst_cnt;

    int n_chk = 0;
    int n_err = 0;
    int exp_cnt = 0;
    int exp_ovf = 0;

    // sequencer: idle -> ife0 -> ife1 -> exec -> wtbk -> idle; issue_total numbers instructions
    int seq_phase   = 0;
    int issue_total = 0;
    int halt_abs    = -1;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        case (seq_phase)
            0: if (run) begin
                seq_phase   <= 1;
                issue_total <= issue_total + 1;
            end
            4: seq_phase <= 0;
            default: seq_phase <= seq_phase + 1;
        endcase
    end

    assign s00_idle = (seq_phase == 0);
    assign s03_exec = (seq_phase == 3);
    assign s04_wtbk = (seq_phase == 4);
    assign halt_req = (seq_phase == 3) && (issue_total == halt_abs);
    assign pc       = PC_W'(issue_total);

    sm_run_ctrl #(.CNT_W(CNT_W), .PC_W(PC_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_step(step), .i_stop(stop),
        .i_clr_cnt(clr_cnt), .i_s00_idle(s00_idle), .i_s03_exec(s03_exec),
        .i_s04_wtbk(s04_wtbk), .i_halt_req(halt_req), .i_pc(pc), .i_brk_en(brk_en),
        .i_brk_addr(brk_addr), .o_run(run), .o_busy(busy), .o_stop_cause(stop_cause),
        .o_inst_cnt(inst_cnt), .o_cnt_ovf(cnt_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0=start 1=step 2=start+step; *_k are 1-based instruction indices in the session (0=none)
    task automatic session(input string tag, input int mode, input int halt_k,
                           input int stop_k, input int stop_ph, input bit brk_on,
                           input int brk_k, input bit clr_wtbk, input int hold);
        int  b, end_k, cause, h, tmp;
        bit  prev_wtbk, done, saw_run;
        b = issue_total;
        end_k = (mode == 1) ? 1 : 1000;
        if (halt_k > 0 && halt_k < end_k) end_k = halt_k;
        if (stop_k > 0 && stop_k < end_k) end_k = stop_k;
        if (brk_on && brk_k > 0 && brk_k < end_k) end_k = brk_k;
        if (halt_k == end_k)                    cause = 2;
        else if (brk_on && brk_k == end_k)      cause = 3;
        else if (mode == 1)                     cause = 1;
        else                                    cause = 0;
        if (clr_wtbk) begin
            exp_cnt = 0;
            exp_ovf = 0;
        end else begin
            tmp = exp_cnt + end_k;
            if (tmp >= CNT_M) exp_ovf = 1;
            exp_cnt = tmp % CNT_M;
        end

        halt_abs = (halt_k > 0) ? b + halt_k : -1;
        brk_en   = brk_on;
        brk_addr = PC_W'(b + brk_k);
        start    = (mode != 1);
        step     = (mode != 0);
        h = hold;
        prev_wtbk = 1'b0;
        done = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            h--;
            if (h <= 0) begin
                start = 1'b0;
                step  = 1'b0;
            end
            if (cyc == 0) chk({tag, "_busy_on"}, busy, 1);
            else if (!busy) begin
                chk({tag, "_busy_after_wtbk"}, prev_wtbk, 1);
                done = 1'b1;
            end
            if (!done) begin
                prev_wtbk = (seq_phase == 4);
                stop    = (stop_k > 0) && (seq_phase == stop_ph) && (issue_total == b + stop_k);
                clr_cnt = clr_wtbk && (seq_phase == 4);
            end
        end
        start = 1'b0; step = 1'b0; stop = 1'b0; clr_cnt = 1'b0;
        if (!done) chk({tag, "_timeout"}, 0, 1);
        chk({tag, "_cause"}, stop_cause, cause);
        chk({tag, "_cnt"}, inst_cnt, exp_cnt);
        chk({tag, "_ovf"}, cnt_ovf, exp_ovf);
        saw_run = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (run) saw_run = 1'b1;
        end
        chk({tag, "_run_after"}, saw_run, 0);
        chk({tag, "_retired"}, issue_total - b, end_k);
        halt_abs = -1;
        brk_en = 1'b0;
    endtask

    initial begin
        int ok;
        rst = 1'b1; start = 1'b0; step = 1'b0; stop = 1'b0; clr_cnt = 1'b0;
        brk_en = 1'b0; brk_addr = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_run", run, 0);
        chk("rst_cause", stop_cause, 0);
        chk("rst_cnt", inst_cnt, 0);
        chk("rst_ovf", cnt_ovf, 0);
        rst = 1'b0;
        @(negedge clk);

        // breakpoint at absolute pc 4, then resume must run past it to a halt
        session("brk", 0, 0, 0, 0, 1'b1, 4 - issue_total, 1'b0, 1);
        session("brk_resume", 0, 2, 0, 0, 1'b1, 4 - issue_total, 1'b0, 1);
        session("halt3", 0, 3, 0, 0, 1'b0, 0, 1'b0, 1);
        session("step", 1, 0, 0, 0, 1'b0, 0, 1'b0, 1);
        session("step_held", 1, 0, 0, 0, 1'b0, 0, 1'b0, 5);
        session("stop_ife1", 0, 5, 2, 2, 1'b0, 0, 1'b0, 1);

        clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        exp_cnt = 0;
        exp_ovf = 0;
        chk("clr_idle", inst_cnt, 0);
        session("wrap17", 0, 17, 0, 0, 1'b0, 0, 1'b0, 1);
        session("clr_wtbk", 1, 0, 0, 0, 1'b0, 0, 1'b1, 1);

        for (int i = 0; i < 12; i++) begin
            int m, hk, sk;
            m  = int'($urandom_range(0, 1));
            hk = int'($urandom_range(1, 6));
            sk = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : 0;
            session($sformatf("rnd%0d", i), m, hk, sk, int'($urandom_range(1, 4)),
                    1'($urandom_range(0, 1)), int'($urandom_range(1, 6)), 1'b0,
                    (m == 1) ? int'($urandom_range(1, 5)) : 1);
        end

        // reset while executing in RUN drops control without counting the retire
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 0;
        for (int i = 0; i < 20 && ok == 0; i++) begin
            if (seq_phase == 3) ok = 1;
            else @(negedge clk);
        end
        if (ok == 0) chk("rst_exec_timeout", 0, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        exp_ovf = 0;
        chk("rst_exec_busy", busy, 0);
        chk("rst_exec_run", run, 0);
        chk("rst_exec_cause", stop_cause, 0);
        chk("rst_exec_cnt", inst_cnt, 0);
        chk("rst_exec_ovf", cnt_ovf, 0);
        repeat (6) @(negedge clk);
        chk("rst_exec_no_retire", inst_cnt, 0);
        chk("rst_exec_idle", busy, 0);
        session("start_step", 2, 2, 0, 0, 1'b0, 0, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
